sub_bytes_scheduler: RTL and testbench

//  Time-shares one external S-box lane of LANE_BYTES bytes between two requesters:
//  - Round datapath: full 128-bit SubBytes or inverse SubBytes.
//  - Key expansion: 32-bit SubWord, forward only.

---
 rtl/sub_bytes_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_sub_bytes_scheduler.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_scheduler.sv
// Shares one S-box lane between round SubBytes/InvSubBytes and key SubWord requests.
// Define SUBBYTES_KEY_PRIORITY_EN for fixed key priority; default is round-robin arbitration.
module sub_bytes_scheduler #(
  parameter int LANE_BYTES = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    rnd_in_valid,
  output logic                    rnd_in_ready,
  input  logic [127:0]            rnd_in_state,
  input  logic                    rnd_in_inv,
  output logic                    rnd_out_valid,
  input  logic                    rnd_out_ready,
  output logic [127:0]            rnd_out_state,
  input  logic                    key_in_valid,
  output logic                    key_in_ready,
  input  logic [31:0]             key_in_word,
  output logic                    key_out_valid,
  input  logic                    key_out_ready,
  output logic [31:0]             key_out_word,
  output logic [8*LANE_BYTES-1:0] sbox_in,
  output logic                    sbox_inv,
  input  logic [8*LANE_BYTES-1:0] sbox_out,
  output logic                    busy
);
  localparam int W       = 8 * LANE_BYTES;
  localparam int PASSES  = 16 / LANE_BYTES;
  localparam int PW      = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int TOP_LSB = 128 - W;
  localparam logic [PW-1:0] LAST_PASS = PW'(PASSES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RND_SUB  = 3'd1,
    KEY_SUB  = 3'd2,
    RND_DONE = 3'd3,
    KEY_DONE = 3'd4
  } state_t;

  state_t          state_r;
  logic [PW-1:0]   pass_cnt_r;
  logic [127:0]    src_state_r;
  logic            inv_r;
  logic [31:0]     key_word_r;
  logic [127:0]    rnd_out_state_r;
  logic [31:0]     key_out_word_r;
  logic            rnd_out_valid_r;
  logic            key_out_valid_r;
  logic            busy_r;
  logic            grant_rnd_s;
  logic            grant_key_s;
  logic [6:0]      slice_lsb_s;
  logic [W-1:0]    sbox_in_s;
  logic            sbox_inv_s;
`ifndef SUBBYTES_KEY_PRIORITY_EN
  localparam logic GRANT_KEY = 1'b1;
  logic            last_grant_r;
`endif

  // Pass p works on the p-th slice counted from the MSB end of the state.
  assign slice_lsb_s = 7'(TOP_LSB) - 7'(pass_cnt_r) * 7'(W);

  // Arbitration; only meaningful in IDLE, and the grant doubles as in_ready.
  always_comb begin
    grant_rnd_s = 1'b0;
    grant_key_s = 1'b0;
    if ((state_r == IDLE) && !reset) begin
`ifdef SUBBYTES_KEY_PRIORITY_EN
      grant_key_s = key_in_valid;
      grant_rnd_s = rnd_in_valid && !key_in_valid;
`else
      if (rnd_in_valid && key_in_valid) begin
        grant_rnd_s = (last_grant_r == GRANT_KEY);
        grant_key_s = (last_grant_r != GRANT_KEY);
      end else begin
        grant_rnd_s = rnd_in_valid;
        grant_key_s = key_in_valid;
      end
`endif
    end else begin
      grant_rnd_s = 1'b0;
      grant_key_s = 1'b0;
    end
  end

  // Lane drive: the shared S-box answers in the same cycle, so this decodes held registers.
  always_comb begin
    sbox_in_s  = '0;
    sbox_inv_s = 1'b0;
    case (state_r)
      RND_SUB: begin
        sbox_in_s  = src_state_r[slice_lsb_s +: W];
        sbox_inv_s = inv_r;
      end
      KEY_SUB: sbox_in_s[31:0] = key_word_r;
      default: begin
        sbox_in_s  = '0;
        sbox_inv_s = 1'b0;
      end
    endcase
  end

  // Scheduler FSM, operand latches and result registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r         <= IDLE;
      pass_cnt_r      <= '0;
      src_state_r     <= 128'd0;
      inv_r           <= 1'b0;
      key_word_r      <= 32'd0;
      rnd_out_state_r <= 128'd0;
      key_out_word_r  <= 32'd0;
      rnd_out_valid_r <= 1'b0;
      key_out_valid_r <= 1'b0;
      busy_r          <= 1'b0;
`ifndef SUBBYTES_KEY_PRIORITY_EN
      last_grant_r    <= GRANT_KEY;
`endif
    end else begin
      case (state_r)
        IDLE: begin
`ifndef SUBBYTES_KEY_PRIORITY_EN
          if (rnd_in_valid && key_in_valid) begin
            last_grant_r <= grant_key_s;
          end else begin
            last_grant_r <= last_grant_r;
          end
`endif
          if (grant_rnd_s) begin
            src_state_r <= rnd_in_state;
            inv_r       <= rnd_in_inv;
            pass_cnt_r  <= '0;
            busy_r      <= 1'b1;
            state_r     <= RND_SUB;
          end else if (grant_key_s) begin
            key_word_r  <= key_in_word;
            busy_r      <= 1'b1;
            state_r     <= KEY_SUB;
          end else begin
            state_r     <= IDLE;
          end
        end
        RND_SUB: begin
          rnd_out_state_r[slice_lsb_s +: W] <= sbox_out;
          if (pass_cnt_r == LAST_PASS) begin
            pass_cnt_r      <= '0;
            rnd_out_valid_r <= 1'b1;
            state_r         <= RND_DONE;
          end else begin
            pass_cnt_r      <= pass_cnt_r + PW'(1);
          end
        end
        KEY_SUB: begin
          key_out_word_r  <= sbox_out[31:0];
          key_out_valid_r <= 1'b1;
          state_r         <= KEY_DONE;
        end
        RND_DONE: begin
          if (rnd_out_ready) begin
            rnd_out_valid_r <= 1'b0;
            busy_r          <= 1'b0;
            state_r         <= IDLE;
          end else begin
            state_r         <= RND_DONE;
          end
        end
        KEY_DONE: begin
          if (key_out_ready) begin
            key_out_valid_r <= 1'b0;
            busy_r          <= 1'b0;
            state_r         <= IDLE;
          end else begin
            state_r         <= KEY_DONE;
          end
        end
        default: begin
          rnd_out_valid_r <= 1'b0;
          key_out_valid_r <= 1'b0;
          busy_r          <= 1'b0;
          state_r         <= IDLE;
        end
      endcase
    end
  end

  assign rnd_in_ready  = grant_rnd_s;
  assign key_in_ready  = grant_key_s;
  assign rnd_out_valid = rnd_out_valid_r;
  assign rnd_out_state = rnd_out_state_r;
  assign key_out_valid = key_out_valid_r;
  assign key_out_word  = key_out_word_r;
  assign sbox_in       = sbox_in_s;
  assign sbox_inv      = sbox_inv_s;
  assign busy          = busy_r;
endmodule

// File: tb/tb_sub_bytes_scheduler.sv
// Directed bench for sub_bytes_scheduler with a behavioural AES S-box lane (LANE_BYTES=4).
module tb_sub_bytes_scheduler;
  logic         clock = 1'b0;
  logic         reset;
  logic         rnd_in_valid, rnd_in_ready, rnd_in_inv;
  logic [127:0] rnd_in_state, rnd_out_state;
  logic         rnd_out_valid, rnd_out_ready;
  logic         key_in_valid, key_in_ready, key_out_valid, key_out_ready;
  logic [31:0]  key_in_word, key_out_word;
  logic [31:0]  sbox_in, sbox_out;
  logic         sbox_inv, busy;
  logic [7:0]   fwd_t [256];
  logic [7:0]   inv_t [256];
  int           checks = 0;
  int           errors = 0;

  localparam logic [127:0] PT = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] CT = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [31:0]  KW = 32'hcf4f3c09;
  localparam logic [31:0]  KS = 32'h8a84eb01;

  always #5 clock = ~clock;

  sub_bytes_scheduler #(.LANE_BYTES(4)) dut (
    .clock(clock), .reset(reset),
    .rnd_in_valid(rnd_in_valid), .rnd_in_ready(rnd_in_ready),
    .rnd_in_state(rnd_in_state), .rnd_in_inv(rnd_in_inv),
    .rnd_out_valid(rnd_out_valid), .rnd_out_ready(rnd_out_ready),
    .rnd_out_state(rnd_out_state),
    .key_in_valid(key_in_valid), .key_in_ready(key_in_ready),
    .key_in_word(key_in_word),
    .key_out_valid(key_out_valid), .key_out_ready(key_out_ready),
    .key_out_word(key_out_word),
    .sbox_in(sbox_in), .sbox_inv(sbox_inv), .sbox_out(sbox_out), .busy(busy)
  );

  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign sbox_out[8*g +: 8] = sbox_inv ? inv_t[sbox_in[8*g +: 8]] : fwd_t[sbox_in[8*g +: 8]];
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_fn(input logic [7:0] x);
    logic [7:0] r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, x);
    if (x == 8'h00) r = 8'h00;
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    rnd_in_valid = 1'b0; rnd_in_state = 128'd0; rnd_in_inv = 1'b0; rnd_out_ready = 1'b0;
    key_in_valid = 1'b0; key_in_word = 32'd0; key_out_ready = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Called at the negedge following the accept edge; counts edges from the accept edge.
  task automatic wait_rnd(output int edges);
    edges = 1;
    while (!rnd_out_valid && edges < 40) begin
      @(posedge clock); edges++; @(negedge clock);
    end
    checks++;
    if (rnd_out_valid !== 1'b1) begin
      errors++; $display("FAIL rnd_out_valid_timeout got %b want 1", rnd_out_valid);
    end
  endtask

  task automatic wait_key(output int edges);
    edges = 1;
    while (!key_out_valid && edges < 40) begin
      @(posedge clock); edges++; @(negedge clock);
    end
    checks++;
    if (key_out_valid !== 1'b1) begin
      errors++; $display("FAIL key_out_valid_timeout got %b want 1", key_out_valid);
    end
  endtask

  task automatic pop_rnd();
    rnd_out_ready = 1'b1; @(posedge clock); @(negedge clock); rnd_out_ready = 1'b0;
  endtask

  task automatic pop_key();
    key_out_ready = 1'b1; @(posedge clock); @(negedge clock); key_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({rnd_in_ready, rnd_out_valid, key_in_ready, key_out_valid, sbox_inv, busy} !== 6'b0) begin
      errors++; $display("FAIL reset_flags got %b want 000000",
        {rnd_in_ready, rnd_out_valid, key_in_ready, key_out_valid, sbox_inv, busy});
    end
    checks++;
    if (rnd_out_state !== 128'd0 || key_out_word !== 32'd0 || sbox_in !== 32'd0) begin
      errors++; $display("FAIL reset_data got %h %h %h want zeros", rnd_out_state, key_out_word, sbox_in);
    end
  endtask

  task automatic run_round(input string name, input logic [127:0] din, input logic inv,
                           input logic [127:0] exp);
    int lat;
    rnd_in_valid = 1'b1; rnd_in_state = din; rnd_in_inv = inv;
    #1;
    checks++;
    if (rnd_in_ready !== 1'b1) begin
      errors++; $display("FAIL %s_in_ready got %b want 1", name, rnd_in_ready);
    end
    @(posedge clock); @(negedge clock);
    rnd_in_valid = 1'b0;
    checks++;
    if (sbox_in !== din[127:96] || sbox_inv !== inv) begin
      errors++; $display("FAIL %s_lane_pass0 got %h/%b want %h/%b", name, sbox_in, sbox_inv, din[127:96], inv);
    end
    wait_rnd(lat);
    checks++;
    if (lat !== 5) begin
      errors++; $display("FAIL %s_latency got %0d want 5", name, lat);
    end
    checks++;
    if (rnd_out_state !== exp) begin
      errors++; $display("FAIL %s_data got %h want %h", name, rnd_out_state, exp);
    end
    pop_rnd();
    checks++;
    if (busy !== 1'b0 || rnd_out_valid !== 1'b0) begin
      errors++; $display("FAIL %s_return_idle got busy=%b valid=%b want 0 0", name, busy, rnd_out_valid);
    end
  endtask

  task automatic test_round_fwd();
    run_round("round_fwd", PT, 1'b0, CT);
  endtask

  task automatic test_round_inv();
    run_round("round_inv", CT, 1'b1, PT);
  endtask

  task automatic test_key();
    int lat;
    key_in_valid = 1'b1; key_in_word = KW;
    #1;
    checks++;
    if (key_in_ready !== 1'b1) begin
      errors++; $display("FAIL key_in_ready got %b want 1", key_in_ready);
    end
    @(posedge clock); @(negedge clock);
    key_in_valid = 1'b0;
    checks++;
    if (sbox_in !== KW || sbox_inv !== 1'b0) begin
      errors++; $display("FAIL key_lane got %h/%b want %h/0", sbox_in, sbox_inv, KW);
    end
    wait_key(lat);
    checks++;
    if (lat !== 2 || key_out_word !== KS) begin
      errors++; $display("FAIL key_result got lat=%0d word=%h want lat=2 word=%h", lat, key_out_word, KS);
    end
    pop_key();
  endtask

  task automatic test_contention();
    int  lat;
    logic exp_key_first;
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
`ifdef SUBBYTES_KEY_PRIORITY_EN
      exp_key_first = 1'b1;
`else
      exp_key_first = (rep == 1);
`endif
      rnd_in_valid = 1'b1; rnd_in_state = PT; rnd_in_inv = 1'b0;
      key_in_valid = 1'b1; key_in_word = KW;
      #1;
      checks++;
      if ({rnd_in_ready, key_in_ready} !== (exp_key_first ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL contention_grant%0d got rnd=%b key=%b want key_first=%b",
                           rep, rnd_in_ready, key_in_ready, exp_key_first);
      end
      @(posedge clock); @(negedge clock);
      if (exp_key_first) begin
        key_in_valid = 1'b0;
        wait_key(lat);
        checks++;
        if (key_out_word !== KS) begin
          errors++; $display("FAIL contention_key%0d got %h want %h", rep, key_out_word, KS);
        end
        pop_key();
        #1;
        checks++;
        if (rnd_in_ready !== 1'b1) begin
          errors++; $display("FAIL contention_second_rnd%0d got %b want 1", rep, rnd_in_ready);
        end
        @(posedge clock); @(negedge clock);
        rnd_in_valid = 1'b0;
        wait_rnd(lat);
        checks++;
        if (rnd_out_state !== CT) begin
          errors++; $display("FAIL contention_rnd%0d got %h want %h", rep, rnd_out_state, CT);
        end
        pop_rnd();
      end else begin
        rnd_in_valid = 1'b0;
        wait_rnd(lat);
        checks++;
        if (rnd_out_state !== CT || key_in_ready !== 1'b0) begin
          errors++; $display("FAIL contention_rnd%0d got %h kr=%b want %h kr=0", rep, rnd_out_state, key_in_ready, CT);
        end
        pop_rnd();
        #1;
        checks++;
        if (key_in_ready !== 1'b1) begin
          errors++; $display("FAIL contention_second_key%0d got %b want 1", rep, key_in_ready);
        end
        @(posedge clock); @(negedge clock);
        key_in_valid = 1'b0;
        wait_key(lat);
        checks++;
        if (key_out_word !== KS) begin
          errors++; $display("FAIL contention_key%0d got %h want %h", rep, key_out_word, KS);
        end
        pop_key();
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    rnd_in_valid = 1'b1; rnd_in_state = PT; rnd_in_inv = 1'b0;
    @(posedge clock); @(negedge clock);
    wait_rnd(lat);
    key_in_valid = 1'b1; key_in_word = KW;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); @(negedge clock);
      checks++;
      if (rnd_out_state !== CT ||
          {rnd_out_valid, rnd_in_ready, key_in_ready, busy} !== 4'b1001) begin
        errors++; $display("FAIL backpressure_hold%0d got %h v/rr/kr/busy=%b want %h 1001", i, rnd_out_state,
                           {rnd_out_valid, rnd_in_ready, key_in_ready, busy}, CT);
      end
    end
    rnd_in_valid = 1'b0; key_in_valid = 1'b0;
    pop_rnd();
    checks++;
    if (busy !== 1'b0 || rnd_out_valid !== 1'b0) begin
      errors++; $display("FAIL backpressure_release got busy=%b valid=%b want 0 0", busy, rnd_out_valid);
    end
  endtask

  task automatic test_reset_midop();
    int seen = 0;
    rnd_in_valid = 1'b1; rnd_in_state = CT; rnd_in_inv = 1'b1;
    @(posedge clock); @(negedge clock);
    rnd_in_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (sbox_in !== CT[63:32]) begin
      errors++; $display("FAIL midop_pass2_lane got %h want %h", sbox_in, CT[63:32]);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (rnd_out_state !== 128'd0 || sbox_in !== 32'd0 ||
        {rnd_out_valid, sbox_inv, busy, rnd_in_ready, key_in_ready} !== 5'b0) begin
      errors++; $display("FAIL midop_reset_outputs got %h %h %b want zeros", rnd_out_state, sbox_in,
                         {rnd_out_valid, sbox_inv, busy, rnd_in_ready, key_in_ready});
    end
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); @(negedge clock);
      if (rnd_out_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL midop_no_stale got %0d active cycles want 0", seen);
    end
    run_round("midop_fresh", CT, 1'b1, PT);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int x = 0; x < 256; x++) begin
      fwd_t[x] = sbox_fn(8'(x));
      inv_t[fwd_t[x]] = 8'(x);
    end
    test_reset();
    test_round_fwd();
    test_round_inv();
    test_key();
    test_contention();
    test_backpressure();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
